instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port fetched, decoupled.in, fetch_entry_t: entries from the instruction fetch stage, with data.pc (gpreg) and data.raw (instr).
REQ-005 SHALL have port issue, decoupled.out, fetch_entry_t: entries to the decode stage.
REQ-006 SHALL have port flush, input, 1: discard all queued and in-transit entries.
REQ-007 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-008 SHALL have port empty, output, 1: count == 0.
REQ-009 SHALL have port full, output, 1: count == DEPTH.

Function
REQ-010 SHALL implement a circular buffer of DEPTH entries with a head (read) pointer and a tail (write) pointer, each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
REQ-011 SHALL define count as tail - head, modulo 2^($clog2(DEPTH)+1); empty when the pointers are equal, full when they differ only in the MSB.
REQ-012 SHALL drive fetched.ready = !full && !flush, combinationally.
REQ-013 SHALL drive issue.valid = !empty && !flush, and issue.data = the entry at head[$clog2(DEPTH)-1:0].
REQ-014 SHALL perform an enqueue when fetched.valid && fetched.ready: write the entry at the tail and increment the tail on the next edge.
REQ-015 SHALL perform a dequeue when issue.valid && issue.ready: increment the head on the next edge.
REQ-016 SHALL, on a simultaneous enqueue and dequeue, advance both pointers and leave count unchanged.
REQ-017 SHALL keep fetched.ready low when full, even if a dequeue occurs in the same cycle; there is no full-and-dequeue pass-through.
REQ-018 SHALL wrap the pointers naturally at 2^($clog2(DEPTH)+1) with no special-case logic.
REQ-019 SHALL, when flush is high, load head = tail = 0 on the next edge, with no enqueue and no dequeue in that cycle; the entry on the fetched port is dropped.
REQ-020 SHALL give a latency of 1 cycle from enqueue to issue.valid when the queue is empty, in the default build.
REQ-021 SHALL hold issue.data stable while issue.valid && !issue.ready.
REQ-022 SHALL leave storage contents uninitialised and never reset them.

Reset
REQ-023 SHALL, while rst is high, hold head = 0, tail = 0, count = 0, empty = 1, full = 0, issue.valid = 0 and fetched.ready = 0.
REQ-024 SHALL make fetched.ready = 1 in the first cycle after rst is released, provided flush is low.
REQ-025 SHALL, on rst asserted mid-operation, discard all entries immediately; no enqueue or dequeue handshake completes in any cycle in which rst is high.

Configuration
REQ-026 SHALL support the macro INSTR_QUEUE_BYPASS_EN.
REQ-027 SHALL, with INSTR_QUEUE_BYPASS_EN defined: when empty && fetched.valid && !flush, drive issue.valid = 1 and issue.data = fetched.data combinationally.
REQ-028 SHALL, in that bypass case, write the entry to storage and advance the tail only if issue.ready is low; if issue.ready is high, the pointers stay unchanged (0-cycle latency).
REQ-029 SHALL, without INSTR_QUEUE_BYPASS_EN, never form a combinational path from fetched to issue.

Structure
REQ-030 SHALL define fetch_entry_t (pc: gpreg, raw: instr) and the constant IQ_DEPTH_DEFAULT = 4 in the shared types package; instr_fetch's fetched output SHALL use this type.
REQ-031 SHALL instantiate one sub-module, wrap_ptr (parameter W, inputs inc and clr, output value), for each of head and tail.

Verification
REQ-032 Reset then 4 enqueues with pc 0x0,0x4,0x8,0xC and issue.ready = 0 -> full = 1, count = 4, fetched.ready = 0; then issue.ready = 1 -> pcs issued in order 0x0,0x4,0x8,0xC over 4 cycles.
REQ-033 Continuous enqueue and dequeue for 20 entries with DEPTH = 4 -> count stays at 1, pointers wrap at least twice, no entry lost or duplicated.
REQ-034 Queue holds 3 entries and flush is pulsed for 1 cycle while fetched.valid = 1 -> issue.valid = 0 during the flush cycle, count = 0 the next cycle, and the flushed pc never appears on issue.
REQ-035 rst asserted with 2 entries queued -> issue.valid = 0 and count = 0 in the same cycle; after release, a new pc 0x100 is issued first.
REQ-036 With INSTR_QUEUE_BYPASS_EN, queue empty, enqueue pc 0x40 with issue.ready = 1 -> issue.valid = 1 with pc 0x40 in the same cycle and count stays 0; without the macro -> pc 0x40 appears 1 cycle later.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// ============================================================================
// Module      : instr_queue_pkg
// Description : Shared fetch/decode types and queue defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_queue_pkg;

   typedef logic [31:0] gpreg;
   typedef logic [31:0] instr;

   typedef struct packed {
      gpreg pc;
      instr raw;
   } fetch_entry_t;

   localparam int unsigned IQ_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/instr_queue_wrap_ptr.sv
// ============================================================================
// Module      : wrap_ptr
// Description : Free-running W-bit pointer with increment and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_ptr #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] value_o
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   // Clear wins over increment; wrap is the natural modulo-2^W rollover.
   always_comb begin
      value_d = value_q;
      if (clr_i)
         value_d = '0;
      else if (inc_i)
         value_d = value_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value_q <= '0;
      else
         value_q <= value_d;
   end

   assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/instr_queue.sv
// ============================================================================
// Module      : instr_queue
// Description : Circular fetch-to-decode instruction queue.
//               Optional macro INSTR_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetched_valid_i,
   output logic                     fetched_ready_o,
   input  fetch_entry_t             fetched_data_i,
   output logic                     issue_valid_o,
   input  logic                     issue_ready_i,
   output fetch_entry_t             issue_data_o,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          enq;
   logic          deq;
   logic          bypass;

   fetch_entry_t  mem_q [DEPTH];

   wrap_ptr #(.W(PW)) u_head (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (deq),
      .clr_i   (flush_i),
      .value_o (head)
   );

   wrap_ptr #(.W(PW)) u_tail (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (enq),
      .clr_i   (flush_i),
      .value_o (tail)
   );

   assign count_o = tail - head;
   assign empty_o = (head == tail);
   assign full_o  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

   // rst gating keeps both handshakes closed while reset is applied.
   assign fetched_ready_o = !full_o && !flush_i && !rst;

`ifdef INSTR_QUEUE_BYPASS_EN
   assign bypass        = empty_o && fetched_valid_i && !flush_i && !rst;
   assign issue_valid_o = (!empty_o || bypass) && !flush_i && !rst;
   assign issue_data_o  = bypass ? fetched_data_i : mem_q[head[AW-1:0]];
   // A bypassed entry consumed this cycle never touches storage.
   assign enq = fetched_valid_i && fetched_ready_o && !(bypass && issue_ready_i);
   assign deq = issue_valid_o && issue_ready_i && !bypass;
`else
   assign bypass        = 1'b0;
   assign issue_valid_o = !empty_o && !flush_i && !rst;
   assign issue_data_o  = mem_q[head[AW-1:0]];
   assign enq = fetched_valid_i && fetched_ready_o;
   assign deq = issue_valid_o && issue_ready_i;
`endif

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (enq)
         mem_q[tail[AW-1:0]] <= fetched_data_i;
   end

   logic unused_bypass;
   assign unused_bypass = bypass;

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ============================================================================
// Module      : tb_instr_queue
// Description : Directed table-driven bench for instr_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_queue;
   import instr_queue_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         fv;
   logic         fr;
   fetch_entry_t fdata;
   logic         iv;
   logic         ir;
   fetch_entry_t idata;
   logic         flush;
   logic [2:0]   cnt;
   logic         empty;
   logic         full;

   int n_tests = 0;
   int n_fail  = 0;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetched_valid_i (fv),
      .fetched_ready_o (fr),
      .fetched_data_i  (fdata),
      .issue_valid_o   (iv),
      .issue_ready_i   (ir),
      .issue_data_o    (idata),
      .flush_i         (flush),
      .count_o         (cnt),
      .empty_o         (empty),
      .full_o          (full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic        ir;
      logic        fl;
      logic        exp_iv;
      logic [31:0] exp_pc;
      int          exp_cnt;
      logic        exp_fr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive at the falling edge, compare before the next rising edge.
   task automatic apply(input string tag, input logic v, input logic [31:0] pc,
                        input logic r, input logic f, input logic e_iv,
                        input logic [31:0] e_pc, input int e_cnt, input logic e_fr);
      @(negedge clk);
      fv = v; fdata.pc = pc; fdata.raw = ~pc; ir = r; flush = f;
      #2;
      chk({tag, ".iv"}, {31'b0, iv}, {31'b0, e_iv});
      if (e_iv) chk({tag, ".pc"}, idata.pc, e_pc);
      chk({tag, ".cnt"}, {29'b0, cnt}, e_cnt);
      chk({tag, ".fr"}, {31'b0, fr}, {31'b0, e_fr});
      chk({tag, ".full"}, {31'b0, full}, {31'b0, (e_cnt == DEPTH)});
      chk({tag, ".empty"}, {31'b0, empty}, {31'b0, (e_cnt == 0)});
   endtask

   vec_t tbl [10];

   initial begin
      // Fill to full, attempt enqueue while full with a dequeue, then drain.
      tbl[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1};
      tbl[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 32'h0, 1, 1'b1};
      tbl[2] = '{1'b1, 32'h8,  1'b0, 1'b0, 1'b1, 32'h0, 2, 1'b1};
      tbl[3] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'h0, 3, 1'b1};
      tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h0, 4, 1'b0};
      tbl[5] = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h0, 4, 1'b0};
      tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h4, 3, 1'b1};
      tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h8, 2, 1'b1};
      tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hC, 1, 1'b1};
      tbl[9] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b1};

      rst = 1'b1; fv = 1'b0; ir = 1'b0; flush = 1'b0; fdata = '0;
      #2;
      chk("rst.cnt",   {29'b0, cnt}, 0);
      chk("rst.empty", {31'b0, empty}, 1);
      chk("rst.full",  {31'b0, full}, 0);
      chk("rst.iv",    {31'b0, iv}, 0);
      chk("rst.fr",    {31'b0, fr}, 0);
      #5 rst = 1'b0;

      for (int i = 0; i < 10; i++)
         apply($sformatf("tbl%0d", i), tbl[i].fv, tbl[i].pc, tbl[i].ir, tbl[i].fl,
               tbl[i].exp_iv, tbl[i].exp_pc, tbl[i].exp_cnt, tbl[i].exp_fr);

      // Streaming: one entry in flight, 20 simultaneous enq/deq, pointers wrap.
      apply("strm.pre", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1);
      for (int i = 0; i < 20; i++)
         apply($sformatf("strm%0d", i), 1'b1, 32'h200 + 32'(4 * (i + 1)), 1'b1, 1'b0,
               1'b1, 32'h200 + 32'(4 * i), 1, 1'b1);
      apply("strm.last", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h250, 1, 1'b1);
      apply("strm.done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1);

      // Flush with three queued and a new entry presented.
      apply("fl.e0", 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b1);
      apply("fl.e1", 1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 32'h300, 1, 1'b1);
      apply("fl.e2", 1'b1, 32'h308, 1'b0, 1'b0, 1'b1, 32'h300, 2, 1'b1);
      apply("fl.hit", 1'b1, 32'h3FC, 1'b1, 1'b1, 1'b0, 32'h0,  3, 1'b0);
      apply("fl.aft", 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1);
      apply("fl.aft2", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1);

      // Asynchronous reset with two entries queued.
      apply("rs.e0", 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b1);
      apply("rs.e1", 1'b1, 32'h504, 1'b0, 1'b0, 1'b1, 32'h500, 1, 1'b1);
      @(negedge clk);
      fv = 1'b0; ir = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rs.iv",  {31'b0, iv}, 0);
      chk("rs.cnt", {29'b0, cnt}, 0);
      chk("rs.fr",  {31'b0, fr}, 0);
      @(negedge clk);
      rst = 1'b0;
      apply("rs.new", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b1);
      apply("rs.iss", 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h100, 1, 1'b1);
      apply("rs.end", 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   0, 1'b1);

      // Enqueue into an empty queue with the consumer ready.
`ifdef INSTR_QUEUE_BYPASS_EN
      apply("bp.same", 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 0, 1'b1);
      apply("bp.next", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1);
`else
      apply("bp.same", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1);
      apply("bp.next", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h40, 1, 1'b1);
      apply("bp.done", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
